// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stage controls out.
// master = pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_branch_taken;
    logic [4:0]       mem_rd;
    logic [4:0]       wb_rd;
    logic             mem_reg_write;
    logic             wb_reg_write;
    logic             imem_ready;
    logic             dmem_req;
    logic             dmem_ready;
    logic             cnt_clr;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_branch_taken,
        output mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        output imem_ready, dmem_req, dmem_ready, cnt_clr,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush,
        input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_branch_taken,
        input  mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        input  imem_ready, dmem_req, dmem_ready, cnt_clr,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_flush,
        output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer, EX forwarding selects and perf counters
// for the 5-stage pipeline register bank.
module pipeline_hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DMEM_TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, DWAIT} state_t;

    state_t           state;
    state_t           state_nx;
    logic [15:0]      wait_cnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             timeout_q;
    logic             mem_wait;
    logic             load_use;
    logic             stall_ev;
    logic             flush_ev;

    always_comb begin
        load_use = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
                   ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                    (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        mem_wait = ((state == DWAIT) || hz.dmem_req) && !hz.dmem_ready;
    end

    always_comb begin
        state_nx        = state;
        hz.pc_en        = 1'b1;
        hz.if_id_en     = 1'b1;
        hz.id_ex_en     = 1'b1;
        hz.ex_mem_en    = 1'b1;
        hz.mem_wb_en    = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.mem_wb_flush = 1'b0;
        hz.fwd_a_sel    = 2'b00;
        hz.fwd_b_sel    = 2'b00;
        stall_ev        = 1'b0;
        flush_ev        = 1'b0;
        case (state)
            RUN:     if (hz.dmem_req && !hz.dmem_ready) state_nx = DWAIT;
            DWAIT:   if (hz.dmem_ready) state_nx = RUN;
            default: state_nx = RUN;
        endcase
        if (mem_wait) begin
            hz.pc_en        = 1'b0;
            hz.if_id_en     = 1'b0;
            hz.id_ex_en     = 1'b0;
            hz.ex_mem_en    = 1'b0;
            hz.mem_wb_flush = 1'b1;
            stall_ev        = 1'b1;
        end else if (hz.ex_branch_taken) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
            flush_ev       = 1'b1;
        end else if (load_use) begin
            hz.pc_en       = 1'b0;
            hz.if_id_en    = 1'b0;
            hz.id_ex_flush = 1'b1;
            stall_ev       = 1'b1;
        end else if (!hz.imem_ready) begin
            hz.pc_en       = 1'b0;
            hz.if_id_flush = 1'b1;
            stall_ev       = 1'b1;
        end
        // MEM result is younger than WB, so it wins
        if (hz.mem_reg_write && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs1)
            hz.fwd_a_sel = 2'b10;
        else if (hz.wb_reg_write && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs1)
            hz.fwd_a_sel = 2'b01;
        if (hz.mem_reg_write && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs2)
            hz.fwd_b_sel = 2'b10;
        else if (hz.wb_reg_write && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs2)
            hz.fwd_b_sel = 2'b01;
        if (!reset) begin
            hz.pc_en        = 1'b0;
            hz.if_id_en     = 1'b0;
            hz.id_ex_en     = 1'b0;
            hz.ex_mem_en    = 1'b0;
            hz.mem_wb_en    = 1'b0;
            hz.if_id_flush  = 1'b0;
            hz.id_ex_flush  = 1'b0;
            hz.mem_wb_flush = 1'b0;
            hz.fwd_a_sel    = 2'b00;
            hz.fwd_b_sel    = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state == DWAIT && !hz.dmem_ready) begin
                if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= 16'd0;
            end
            if (hz.cnt_clr)
                timeout_q <= 1'b0;
            else if (state == DWAIT && !hz.dmem_ready &&
                     wait_cnt >= 16'(DMEM_TIMEOUT - 1))
                timeout_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (hz.cnt_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
            if (flush_ev && flush_q != {CNT_W{1'b1}}) flush_q <= flush_q + 1'b1;
        end
    end

    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;
    assign hz.mem_timeout = timeout_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl against a
// cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    localparam int CW   = 8;
    localparam int TMO  = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        bit       rst_n;
        bit [4:0] id_rs1, id_rs2;
        bit       id_use_rs1, id_use_rs2;
        bit [4:0] ex_rs1, ex_rs2, ex_rd;
        bit       ex_is_load, ex_branch_taken;
        bit [4:0] mem_rd, wb_rd;
        bit       mem_reg_write, wb_reg_write;
        bit       imem_ready, dmem_req, dmem_ready, cnt_clr;
    } stim_t;

    typedef struct {
        bit [4:0] en;
        bit [2:0] fl;
        int       fa, fb, sc, fc;
        bit       to;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(.CNT_W(CW), .DMEM_TIMEOUT(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
    );

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit m_busy;
    int m_wcnt, m_st, m_fl;
    bit m_to;

    function automatic int src(bit mw, int mrd, bit ww, int wrd, int rs);
        if (mw && mrd != 0 && mrd == rs) return 2;
        if (ww && wrd != 0 && wrd == rs) return 1;
        return 0;
    endfunction

    task automatic model_step(input stim_t s, output exp_t e);
        bit waiting, lu, stall, brflush;
        e = '{en: 5'b0, fl: 3'b0, fa: 0, fb: 0, sc: 0, fc: 0, to: 1'b0};
        if (!s.rst_n) begin
            m_busy = 0; m_wcnt = 0; m_st = 0; m_fl = 0; m_to = 0;
            return;
        end
        e.sc = m_st; e.fc = m_fl; e.to = m_to;
        waiting = (m_busy || s.dmem_req) && !s.dmem_ready;
        lu = s.ex_is_load && s.ex_rd != 0 &&
             ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) ||
              (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
        stall = 0; brflush = 0;
        e.en = 5'b11111;
        if (waiting)               begin e.en = 5'b00001; e.fl = 3'b001; stall = 1; end
        else if (s.ex_branch_taken) begin e.fl = 3'b110; brflush = 1; end
        else if (lu)               begin e.en = 5'b00111; e.fl = 3'b010; stall = 1; end
        else if (!s.imem_ready)    begin e.en = 5'b01111; e.fl = 3'b100; stall = 1; end
        e.fa = src(s.mem_reg_write, s.mem_rd, s.wb_reg_write, s.wb_rd, s.ex_rs1);
        e.fb = src(s.mem_reg_write, s.mem_rd, s.wb_reg_write, s.wb_rd, s.ex_rs2);
        if (m_busy && !s.dmem_ready && m_wcnt + 1 >= TMO) m_to = 1;
        if (s.cnt_clr) begin
            m_st = 0; m_fl = 0; m_to = 0;
        end else begin
            if (stall && m_st < CMAX) m_st++;
            if (brflush && m_fl < CMAX) m_fl++;
        end
        m_wcnt = (m_busy && !s.dmem_ready) ? m_wcnt + 1 : 0;
        m_busy = waiting;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1; s.imem_ready = 1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset              = s.rst_n;
        hz.id_rs1          = s.id_rs1;
        hz.id_rs2          = s.id_rs2;
        hz.id_use_rs1      = s.id_use_rs1;
        hz.id_use_rs2      = s.id_use_rs2;
        hz.ex_rs1          = s.ex_rs1;
        hz.ex_rs2          = s.ex_rs2;
        hz.ex_rd           = s.ex_rd;
        hz.ex_is_load      = s.ex_is_load;
        hz.ex_branch_taken = s.ex_branch_taken;
        hz.mem_rd          = s.mem_rd;
        hz.wb_rd           = s.wb_rd;
        hz.mem_reg_write   = s.mem_reg_write;
        hz.wb_reg_write    = s.wb_reg_write;
        hz.imem_ready      = s.imem_ready;
        hz.dmem_req        = s.dmem_req;
        hz.dmem_ready      = s.dmem_ready;
        hz.cnt_clr         = s.cnt_clr;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        model_step(s, e);
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
        end
    endtask

    // monitor: every cycle the DUT presents a control vector
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("enables", int'({hz.pc_en, hz.if_id_en, hz.id_ex_en,
                                     hz.ex_mem_en, hz.mem_wb_en}), int'(e.en));
                chk("flushes", int'({hz.if_id_flush, hz.id_ex_flush,
                                     hz.mem_wb_flush}), int'(e.fl));
                chk("fwd_a_sel", int'(hz.fwd_a_sel), e.fa);
                chk("fwd_b_sel", int'(hz.fwd_b_sel), e.fb);
                chk("stall_cnt", int'(hz.stall_cnt), e.sc);
                chk("flush_cnt", int'(hz.flush_cnt), e.fc);
                chk("mem_timeout", int'(hz.mem_timeout), int'(e.to));
            end
        end
    end

    initial begin
        stim_t s;
        int hold_lo;
        s = idle();
        s.rst_n = 0;
        apply(s);
        drive(s);
        drive(s);
        // load-use, then the load sits in MEM
        s = idle(); s.ex_is_load = 1; s.ex_rd = 5; s.id_use_rs1 = 1; s.id_rs1 = 5;
        drive(s);
        s = idle(); s.mem_rd = 5; s.mem_reg_write = 1; s.ex_rs1 = 5;
        drive(s);
        drive(idle());
        // branch beats load-use
        s = idle(); s.ex_branch_taken = 1; s.ex_is_load = 1; s.ex_rd = 3;
        s.id_use_rs2 = 1; s.id_rs2 = 3;
        drive(s);
        drive(idle());
        // 3 wait cycles then ready
        s = idle(); s.dmem_req = 1;
        repeat (3) drive(s);
        s.dmem_ready = 1;
        drive(s);
        drive(idle());
        // forwarding priority
        s = idle(); s.mem_rd = 7; s.wb_rd = 7; s.mem_reg_write = 1;
        s.wb_reg_write = 1; s.ex_rs1 = 7; s.ex_rs2 = 0;
        drive(s);
        s.mem_reg_write = 0;
        drive(s);
        // timeout, sticky, then clear
        s = idle(); s.dmem_req = 1;
        repeat (7) drive(s);
        s.cnt_clr = 1;
        drive(s);
        s.cnt_clr = 0; s.dmem_ready = 1;
        drive(s);
        drive(idle());
        // reset in the middle of DWAIT
        s = idle(); s.dmem_req = 1;
        repeat (2) drive(s);
        s.rst_n = 0;
        drive(s);
        drive(idle());
        drive(idle());
        // random traffic
        hold_lo = 0;
        for (int i = 0; i < 1500; i++) begin
            s = idle();
            s.id_rs1          = 5'($urandom_range(0, 7));
            s.id_rs2          = 5'($urandom_range(0, 7));
            s.id_use_rs1      = 1'($urandom_range(0, 1));
            s.id_use_rs2      = 1'($urandom_range(0, 1));
            s.ex_rs1          = 5'($urandom_range(0, 7));
            s.ex_rs2          = 5'($urandom_range(0, 7));
            s.ex_rd           = 5'($urandom_range(0, 7));
            s.ex_is_load      = ($urandom_range(0, 2) == 0);
            s.ex_branch_taken = ($urandom_range(0, 6) == 0);
            s.mem_rd          = 5'($urandom_range(0, 7));
            s.wb_rd           = 5'($urandom_range(0, 7));
            s.mem_reg_write   = 1'($urandom_range(0, 1));
            s.wb_reg_write    = 1'($urandom_range(0, 1));
            s.imem_ready      = ($urandom_range(0, 5) != 0);
            s.cnt_clr         = ($urandom_range(0, 99) < 2);
            s.rst_n           = ($urandom_range(0, 199) != 0);
            if (hold_lo == 0 && $urandom_range(0, 29) == 0)
                hold_lo = $urandom_range(3, 8);
            if (hold_lo > 0) begin
                s.dmem_req = 1; s.dmem_ready = 0; hold_lo--;
            end else begin
                s.dmem_req   = ($urandom_range(0, 4) == 0);
                s.dmem_ready = 1'($urandom_range(0, 1));
            end
            drive(s);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
